// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The port index constants are used to pick out bits of the one-hot grant vector.
// The memory request struct carries the package default address and data widths.
package dmem_arb_pkg;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // Bit positions of each requester in the req/gnt vectors.
    localparam int IDX_C = 0;
    localparam int IDX_D = 1;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    // Access size/sign encoding shared with data_mem and the controller.
    localparam logic [2:0] MEM_MODE_B  = 3'b000;
    localparam logic [2:0] MEM_MODE_H  = 3'b001;
    localparam logic [2:0] MEM_MODE_W  = 3'b010;
    localparam logic [2:0] MEM_MODE_BU = 3'b100;
    localparam logic [2:0] MEM_MODE_HU = 3'b101;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [2:0]             mode;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, secondary port and memory port of the data-memory arbiter.
// The slave modport is the arbiter's view of the bundle.
// The master modport is the view of the surrounding requesters and memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Core load/store port
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [2:0]        c_mode;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    // Secondary (debug loader / DMA) port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_mode;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Memory port
    logic              m_rd_en;
    logic              m_wr_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [2:0]        m_mode;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_mode,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_mode,
        output d_gnt, d_rvalid, d_rdata,
        output m_rd_en, m_wr_en, m_addr, m_wdata, m_mode,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_mode,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_mode,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_rd_en, m_wr_en, m_addr, m_wdata, m_mode,
        output m_rdata
    );

endinterface

// File: rtl/dmem_arbiter_arb2.sv
// Two-requester arbiter producing a one-hot grant.
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN.
//   Undefined: round-robin arbitration using a 'last granted' pointer.
//   Defined:   core priority, with a saturating wait counter that forces a D grant.
// Grants are forced low while rst (active-low) is asserted.
module arb2
    import dmem_arb_pkg::*;
`ifdef DMEM_ARB_FIXED_PRIO_EN
#(
    parameter int STARVE_LIMIT = 8
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

    logic [7:0] r_wait;
    logic       w_starved;

    assign w_starved = (r_wait >= 8'(STARVE_LIMIT));

    // Core wins contention unless D has waited long enough.
    always_comb begin
        o_gnt = 2'b00;
        if (rst) begin
            if (i_req == 2'b11) begin
                o_gnt[IDX_D] = w_starved;
                o_gnt[IDX_C] = ~w_starved;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // Count D wait cycles; clear on D grant or when D withdraws.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait <= 8'd0;
        end else if (!i_req[IDX_D] || o_gnt[IDX_D]) begin
            r_wait <= 8'd0;
        end else if (r_wait != 8'hFF) begin
            r_wait <= r_wait + 8'd1;
        end
    end

`else

    port_e r_last;

    // On contention grant the port that did not win last time.
    always_comb begin
        o_gnt = 2'b00;
        if (rst) begin
            if (i_req == 2'b11) begin
                o_gnt[IDX_C] = (r_last == PORT_D);
                o_gnt[IDX_D] = (r_last == PORT_C);
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // Remember the most recently granted port; reset favours the core.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= PORT_D;
        end else if (o_gnt[IDX_C]) begin
            r_last <= PORT_C;
        end else if (o_gnt[IDX_D]) begin
            r_last <= PORT_D;
        end
    end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data memory between the core and a secondary requester.
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN.
//   Undefined: round-robin arbitration.
//   Defined:   core priority with a starvation guard.
// rst is synchronous, active-low.
// The winner's request is steered combinationally to the memory port.
// Load data is registered into the winner's response registers at the accept edge.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);

    // An out-of-range starvation limit leaves this marker block in the hierarchy.
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_starve_limit_out_of_range
    end

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_any_gnt;
    mem_req_t          w_c_req;
    mem_req_t          w_d_req;
    mem_req_t          w_sel;

    logic              r_c_rvalid;
    logic [DATA_W-1:0] r_c_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;

    assign w_req[IDX_C] = bus.c_req;
    assign w_req[IDX_D] = bus.d_req;

    arb2
`ifdef DMEM_ARB_FIXED_PRIO_EN
    #(
        .STARVE_LIMIT (STARVE_LIMIT)
    )
`endif
    u_arb2 (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign w_any_gnt = |w_gnt;

    // Pack each port's attributes and select the granted one (zero when idle).
    always_comb begin
        w_c_req.we    = bus.c_we;
        w_c_req.addr  = DMEM_ADDR_W'(bus.c_addr);
        w_c_req.wdata = DMEM_DATA_W'(bus.c_wdata);
        w_c_req.mode  = bus.c_mode;

        w_d_req.we    = bus.d_we;
        w_d_req.addr  = DMEM_ADDR_W'(bus.d_addr);
        w_d_req.wdata = DMEM_DATA_W'(bus.d_wdata);
        w_d_req.mode  = bus.d_mode;

        w_sel = '0;
        if (w_gnt[IDX_C]) begin
            w_sel = w_c_req;
        end else if (w_gnt[IDX_D]) begin
            w_sel = w_d_req;
        end
    end

    assign bus.c_gnt   = w_gnt[IDX_C];
    assign bus.d_gnt   = w_gnt[IDX_D];

    assign bus.m_rd_en = w_any_gnt & ~w_sel.we;
    assign bus.m_wr_en = w_any_gnt &  w_sel.we;
    assign bus.m_addr  = ADDR_W'(w_sel.addr);
    assign bus.m_wdata = DATA_W'(w_sel.wdata);
    assign bus.m_mode  = w_sel.mode;

    // Capture load data for whichever port won; rvalid pulses for one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_c_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_c_rvalid <= w_gnt[IDX_C] & ~bus.c_we;
            r_d_rvalid <= w_gnt[IDX_D] & ~bus.d_we;
            if (w_gnt[IDX_C] && !bus.c_we) begin
                r_c_rdata <= bus.m_rdata;
            end
            if (w_gnt[IDX_D] && !bus.d_we) begin
                r_d_rdata <= bus.m_rdata;
            end
        end
    end

    assign bus.c_rvalid = r_c_rvalid;
    assign bus.c_rdata  = r_c_rdata;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// Load results are pushed to per-port expectation queues when a grant is seen.
// They are popped and compared when the matching rvalid appears.
// A small word-addressed memory model stands in for data_mem.
// Define DMEM_ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_c [$];
    logic [31:0] exp_d [$];
    logic [31:0] mem   [64];

    function automatic logic [31:0] pat(input logic [5:0] idx);
        return 32'hC0DE_0000 | {26'd0, idx};
    endfunction

    // Memory model: reloads a known pattern during reset, writes on accept edge.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(6'(i));
        end else if (bus.m_wr_en) begin
            mem[bus.m_addr[7:2]] <= bus.m_wdata;
        end
    end

    always_comb bus.m_rdata = mem[bus.m_addr[7:2]];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_mode = MEM_MODE_W;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mode = MEM_MODE_W;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        exp_c.delete();
        exp_d.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h4; bus.c_wdata = '0; bus.c_mode = MEM_MODE_W;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_wdata = 32'h55; bus.d_mode = MEM_MODE_W;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.c_gnt, bus.d_gnt, bus.m_rd_en, bus.m_wr_en} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_gnt cycle %0d: got gnt/en %b required 0000", i,
                         {bus.c_gnt, bus.d_gnt, bus.m_rd_en, bus.m_wr_en});
            end
            n_checks++;
            if ({bus.c_rvalid, bus.d_rvalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_rvalid cycle %0d: got %b required 00", i, {bus.c_rvalid, bus.d_rvalid});
            end
            n_checks++;
            if (bus.c_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata cycle %0d: got c=%h d=%h required 0", i, bus.c_rdata, bus.d_rdata);
            end
            next_cycle();
        end
        idle_inputs();
        rst = 1'b1;
        $display("reset held 3 cycles with both requests high");
    endtask

    task automatic test_lone_core();
        logic [31:0] exp;
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h10; bus.c_wdata = 32'hDEADBEEF; bus.c_mode = MEM_MODE_W;
        @(negedge clk);
        n_checks++;
        if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_store_gnt: got c=%b d=%b required c=1 d=0", bus.c_gnt, bus.d_gnt);
        end
        n_checks++;
        if (bus.m_wr_en !== 1'b1 || bus.m_rd_en !== 1'b0 || bus.m_addr !== 32'h10 ||
            bus.m_wdata !== 32'hDEADBEEF || bus.m_mode !== MEM_MODE_W) begin
            n_fail++;
            $display("FAIL lone_store_mport: got wr=%b rd=%b addr=%h wdata=%h mode=%b required 1 0 10 deadbeef 010",
                     bus.m_wr_en, bus.m_rd_en, bus.m_addr, bus.m_wdata, bus.m_mode);
        end
        $display("C store 0x10 = 0xdeadbeef");
        next_cycle();
        bus.c_we = 1'b0; bus.c_wdata = '0;
        @(negedge clk);
        n_checks++;
        if (bus.c_gnt !== 1'b1 || bus.m_rd_en !== 1'b1 || bus.m_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_load_gnt: got gnt=%b rd=%b wr=%b required 1 1 0", bus.c_gnt, bus.m_rd_en, bus.m_wr_en);
        end
        n_checks++;
        if (bus.c_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_no_resp: got c_rvalid=%b required 0", bus.c_rvalid);
        end
        exp_c.push_back(32'hDEADBEEF);
        $display("C load 0x10");
        next_cycle();
        bus.c_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.c_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_load_rvalid: got c=%b d=%b required c=1 d=0", bus.c_rvalid, bus.d_rvalid);
        end
        if (bus.c_rvalid === 1'b1) begin
            exp = (exp_c.size() > 0) ? exp_c.pop_front() : 32'hxxxxxxxx;
            n_checks++;
            if (bus.c_rdata !== exp) begin
                n_fail++;
                $display("FAIL lone_load_data: got %h required %h", bus.c_rdata, exp);
            end
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.c_rvalid !== 1'b0 || bus.c_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rvalid_pulse_hold: got rvalid=%b rdata=%h required 0 deadbeef", bus.c_rvalid, bus.c_rdata);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic        c_win;
        logic        prev_c = 1'b0;
        logic        prev_d = 1'b0;
        logic [31:0] exp;
        reset_pulse();
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h40; bus.c_mode = MEM_MODE_W;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_mode = MEM_MODE_W;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) idle_inputs();
            @(negedge clk);
            c_win = (i % 2 == 0);
            if (i < 6) begin
                n_checks++;
                if (bus.c_gnt !== c_win || bus.d_gnt !== !c_win) begin
                    n_fail++;
                    $display("FAIL rr_order cycle %0d: got c=%b d=%b required c=%b d=%b",
                             i, bus.c_gnt, bus.d_gnt, c_win, !c_win);
                end
            end
            n_checks++;
            if (bus.c_rvalid !== prev_c || bus.d_rvalid !== prev_d) begin
                n_fail++;
                $display("FAIL rr_rvalid cycle %0d: got c=%b d=%b required c=%b d=%b",
                         i, bus.c_rvalid, bus.d_rvalid, prev_c, prev_d);
            end
            if (bus.c_rvalid === 1'b1) begin
                exp = (exp_c.size() > 0) ? exp_c.pop_front() : 32'hxxxxxxxx;
                n_checks++;
                if (bus.c_rdata !== exp) begin
                    n_fail++;
                    $display("FAIL rr_c_data cycle %0d: got %h required %h", i, bus.c_rdata, exp);
                end
            end
            if (bus.d_rvalid === 1'b1) begin
                exp = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hxxxxxxxx;
                n_checks++;
                if (bus.d_rdata !== exp) begin
                    n_fail++;
                    $display("FAIL rr_d_data cycle %0d: got %h required %h", i, bus.d_rdata, exp);
                end
            end
            if (i < 6) begin
                if (c_win) exp_c.push_back(pat(bus.c_addr[7:2]));
                else       exp_d.push_back(pat(bus.d_addr[7:2]));
                $display("contention cycle %0d: %s load granted", i, c_win ? "C" : "D");
            end
            prev_c = (i < 6) && c_win;
            prev_d = (i < 6) && !c_win;
            next_cycle();
            if (i < 5) begin
                if (c_win) bus.c_addr = bus.c_addr + 32'h4;
                else       bus.d_addr = bus.d_addr + 32'h4;
            end
        end
    endtask

    task automatic test_starvation();
        int wait_m = 0;
        int d_grants = 0;
        logic exp_d_win;
        reset_pulse();
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h40; bus.c_mode = MEM_MODE_W;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_mode = MEM_MODE_W;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            exp_d_win = (wait_m >= 8);
            n_checks++;
            if (bus.d_gnt !== exp_d_win || bus.c_gnt !== !exp_d_win) begin
                n_fail++;
                $display("FAIL starve_gnt cycle %0d: got c=%b d=%b required c=%b d=%b",
                         cyc, bus.c_gnt, bus.d_gnt, !exp_d_win, exp_d_win);
            end
            if (bus.d_gnt === 1'b1) d_grants++;
            $display("fixed-prio cycle %0d: %s granted", cyc, exp_d_win ? "D" : "C");
            wait_m = exp_d_win ? 0 : ((wait_m < 255) ? wait_m + 1 : 255);
            next_cycle();
        end
        n_checks++;
        if (d_grants != 1) begin
            n_fail++;
            $display("FAIL starve_count: got %0d D grants required 1", d_grants);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_mode = MEM_MODE_W;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) bus.c_addr = 32'(4 * i);
            else       idle_inputs();
            @(negedge clk);
            if (i < 4) begin
                n_checks++;
                if (bus.c_gnt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_gnt cycle %0d: got %b required 1", i, bus.c_gnt);
                end
                exp_c.push_back(pat(bus.c_addr[7:2]));
                $display("C back-to-back load %0d addr %h", i, bus.c_addr);
            end
            if (i > 0) begin
                n_checks++;
                if (bus.c_rvalid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_rvalid cycle %0d: got %b required 1", i, bus.c_rvalid);
                end
                exp = (exp_c.size() > 0) ? exp_c.pop_front() : 32'hxxxxxxxx;
                n_checks++;
                if (bus.c_rdata !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_data cycle %0d: got %h required %h", i, bus.c_rdata, exp);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] exp;
        reset_pulse();
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h20; bus.c_wdata = 32'h1234; bus.c_mode = MEM_MODE_W;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_mode = MEM_MODE_W;
        @(negedge clk);
        n_checks++;
        if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL same_addr_first: got c=%b d=%b required c=1 d=0", bus.c_gnt, bus.d_gnt);
        end
        $display("C store 0x20 = 0x1234 (D waits)");
        next_cycle();
        bus.c_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.d_gnt !== 1'b1 || bus.m_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL same_addr_second: got d_gnt=%b rd=%b required 1 1", bus.d_gnt, bus.m_rd_en);
        end
        exp_d.push_back(32'h1234);
        $display("D load 0x20");
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.d_rvalid !== 1'b1 || bus.c_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL same_addr_rvalid: got d=%b c=%b required d=1 c=0", bus.d_rvalid, bus.c_rvalid);
        end
        exp = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (bus.d_rdata !== exp) begin
            n_fail++;
            $display("FAIL same_addr_data: got %h required %h", bus.d_rdata, exp);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h30; bus.d_mode = MEM_MODE_W;
        @(negedge clk);
        n_checks++;
        if (bus.d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_gnt: got %b required 1", bus.d_gnt);
        end
        $display("D load 0x30 then reset");
        next_cycle();
        bus.d_req = 1'b0;
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0 || bus.c_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_drop: got rvalid=%b d_rdata=%h c_rdata=%h required 0 0 0",
                     bus.d_rvalid, bus.d_rdata, bus.c_rdata);
        end
        next_cycle();
        exp_c.delete();
        exp_d.delete();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_lone_core();
`ifdef DMEM_ARB_FIXED_PRIO_EN
        test_starvation();
`else
        test_round_robin();
`endif
        test_back_to_back();
        test_same_addr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single data memory between the core load/store path and a secondary requester (debug loader / DMA) on one clock. It sits between the core's memory stage and `data_mem`, selecting one transaction per cycle, steering it to the memory port, and returning registered read data to the winning requester. The core treats a low `c_gnt` while `c_req` is high as a stall.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 8: D-port wait cycles before a forced grant. Used only in fixed-priority mode; range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `c_req` in 1: core request.
- `c_we` in 1: 1 = store, 0 = load.
- `c_addr` in `ADDR_W`: byte address.
- `c_wdata` in `DATA_W`: store data.
- `c_mode` in 3: `mem_mode` encoding (byte/half/word, signed/unsigned), passed through unchanged.
- `c_gnt` out 1: core transaction accepted this cycle.
- `c_rvalid` out 1: core load data valid.
- `c_rdata` out `DATA_W`: core load data.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_mode`, `d_gnt`, `d_rvalid`, `d_rdata`: same as above, for the secondary port.
- `m_rd_en` out 1: memory read enable.
- `m_wr_en` out 1: memory write enable.
- `m_addr` out `ADDR_W`: memory address.
- `m_wdata` out `DATA_W`: memory write data.
- `m_mode` out 3: memory access mode.
- `m_rdata` in `DATA_W`: combinational read data from `data_mem` `out_data`.

## Operation
Transactions:
- One transaction per cycle.
- A requester raises `req` with stable attributes and holds them until it sees `gnt` high at a clock edge. Accept = `req & gnt` at the edge.
- `gnt` is combinational from `req` and arbitration state. A lone requester is granted in the same cycle.
- The winner's `we`/`addr`/`wdata`/`mode` drive `m_*` combinationally. `m_rd_en = gnt & ~we`, `m_wr_en = gnt & we`.
- With no grant, `m_*` enables are 0 and `m_addr`/`m_wdata`/`m_mode` are 0.
- Store: committed by `data_mem` at the accept edge. No response is returned.
- Load: `m_rdata` is registered at the accept edge into the winner's `rdata`, and that port's `rvalid` pulses high for exactly one cycle.
- `rdata` holds its value until the next load to that port.

Arbitration, round-robin (default):
- Register `last` ∈ {C, D}.
- On contention, grant the port that is not `last`.
- `last` updates to the granted port on every accept.

Reset and boundary behaviour:
- Reset state: `last` = D (core wins the first contention), wait counter = 0, `c_rvalid`/`d_rvalid` = 0, `c_rdata`/`d_rdata` = 0.
- While `rst` is low, `c_gnt`, `d_gnt`, `m_rd_en` and `m_wr_en` are forced to 0, so nothing is accepted.
- Reset asserted the cycle after a load accept: `rvalid` is cleared at that edge and the response is dropped.
- Request dropped before grant: legal. No state change except wait-counter clear.
- Both ports at the same address, one store and one load: serialized by grant order with no forwarding. A load granted after a store sees the new data.

## Timing
- Grant latency: 0 cycles when uncontended; at most 1 extra cycle under round-robin contention.
- Load latency: `rvalid`/`rdata` valid 1 cycle after the accept edge.
- Back-to-back loads on one port: `rvalid` held high on consecutive cycles, with `rdata` updated each cycle.
- Both ports requesting every cycle (round-robin): grants alternate C, D, C, D…
- Throughput: 1 transaction per cycle, 100% utilization while any `req` is high.

## Configuration
`DMEM_ARB_FIXED_PRIO_EN` selects the arbitration scheme.

Defined:
- Core has priority, with a starvation guard.
- 8-bit wait counter: increments, saturating, each cycle `d_req & ~d_gnt`; clears on D accept or `~d_req`.
- When the counter ≥ `STARVE_LIMIT`, D wins contention for one grant, then the counter clears.
- `last` is not implemented.

Undefined:
- Round-robin as described above.
- No wait counter.

## Structure
Package `dmem_arb_pkg` holds:
- `port_e` enum: `PORT_C`, `PORT_D`.
- `mem_req_t` struct: `we`, `addr`, `wdata`, `mode`.
- `mem_mode` localparams shared with `data_mem`/`controller`.

Sub-module `arb2`:
- Inputs: two `req` bits. Outputs: one-hot `gnt`.
- Contains the `last` pointer, or the wait counter under the macro.
- `dmem_arbiter` keeps the request mux and the response registers.

## Test plan
- Reset: hold `rst`=0 with both `req`=1 for 3 cycles → `gnt`=0, `m_wr_en`=`m_rd_en`=0, `rvalid`=0, `rdata`=0.
- Lone core store then load: C store `addr`=0x10, `wdata`=0xDEADBEEF, word mode; then C load 0x10 → `c_gnt` same cycle both times; `c_rvalid` 1 cycle after the load accept with `c_rdata`=0xDEADBEEF; `d_rvalid` stays 0.
- Round-robin contention: both ports load continuously for 6 cycles → grant order C, D, C, D, C, D; each `rvalid` one cycle after its grant.
- Fixed-priority starvation (macro on, `STARVE_LIMIT`=8): `c_req` and `d_req` held high → D granted on the 9th cycle exactly once, then C resumes and the counter restarts.
- Same-address ordering: C store 0x20 = 0x1234 and D load 0x20 raised simultaneously (round-robin, after reset) → C granted first; D's `d_rdata` = 0x1234 on the cycle after its grant.
- Reset mid-operation: D load accepted, `rst`=0 at the next edge → `d_rvalid` stays 0 and `d_rdata` = 0.
